div_unit: RTL and testbench

Iterative 64-bit integer divide/remainder unit for the RV64M DIV, DIVU, REM and REMU instructions and their W forms. It sits in the execute stage beside the single-cycle ALU and takes its operands from the same operand muxes. Its result feeds the execute result mux in place of the ALU output. It holds the pipeline through BUSY while a division is in flight, and it implements the RISC-V divide-by-zero and signed-overflow results exactly.

---
 rtl/div_unit.sv | 184 ++++++++++++++++++
 tb/tb_div_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- iterative 64-bit divide/remainder unit for RV64M
//             (DIV, DIVU, REM, REMU and their W forms).
//
// Restoring radix-2 divider that produces one quotient bit per cycle over a
// fixed 64 iterations. Divide-by-zero and signed overflow are resolved when
// the request is accepted and skip the iteration entirely.
//
// Ports:
//   CLK      in   1   rising-edge clock
//   RESET_N  in   1   asynchronous active-low reset
//   X        in  64   dividend
//   Y        in  64   divisor
//   OP       in   2   0=div, 1=divu, 2=rem, 3=remu
//   W32      in   1   word form (operands and result are 32-bit, sign-extended)
//   START    in   1   request, sampled only in IDLE
//   ABORT    in   1   synchronous flush back to IDLE, beats START
//   OUTPUT   out 64   result, updated only on the DONE edge
//   BUSY     out  1   high while in CALC or FIX
//   DONE     out  1   one-cycle pulse, OUTPUT valid in the same cycle
// -----------------------------------------------------------------------------
module div_unit (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [63:0] X,
  input  logic [63:0] Y,
  input  logic [1:0]  OP,
  input  logic        W32,
  input  logic        START,
  input  logic        ABORT,
  output logic [63:0] OUTPUT,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [5:0]  r_cnt;
  logic [63:0] r_quo;      // dividend shifts out of the top, quotient bits in at the bottom
  logic [63:0] r_rem;
  logic [63:0] r_divisor;  // divisor magnitude
  logic        r_op_rem;
  logic        r_w32;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_special;
  logic [63:0] r_out;
  logic        r_busy;
  logic        r_done;

  // ---------------- operand preparation (combinational, used at START) -----
  logic        w_signed;
  logic [63:0] w_x_ext;
  logic [63:0] w_y_ext;
  logic        w_x_neg;
  logic        w_y_neg;
  logic [63:0] w_x_mag;
  logic [63:0] w_y_mag;
  logic        w_div_zero;
  logic        w_ovf;
  logic        w_special;

  assign w_signed   = ~OP[0];
  assign w_x_ext    = W32 ? {{32{w_signed & X[31]}}, X[31:0]} : X;
  assign w_y_ext    = W32 ? {{32{w_signed & Y[31]}}, Y[31:0]} : Y;
  assign w_x_neg    = w_signed & w_x_ext[63];
  assign w_y_neg    = w_signed & w_y_ext[63];
  assign w_x_mag    = w_x_neg ? (~w_x_ext + 64'd1) : w_x_ext;
  assign w_y_mag    = w_y_neg ? (~w_y_ext + 64'd1) : w_y_ext;
  assign w_div_zero = (w_y_ext == 64'd0);
  assign w_ovf      = w_signed &
                      (W32 ? ((X[31:0] == 32'h8000_0000) && (Y[31:0] == 32'hFFFF_FFFF))
                           : ((X == 64'h8000_0000_0000_0000) && (Y == 64'hFFFF_FFFF_FFFF_FFFF)));
  assign w_special  = w_div_zero | w_ovf;

  // ---------------- one restoring iteration ---------------------------------
  logic [64:0] w_rem_shift;
  logic [64:0] w_trial;
  logic        w_trial_ok;

  assign w_rem_shift = {r_rem, r_quo[63]};
  assign w_trial     = w_rem_shift - {1'b0, r_divisor};
  assign w_trial_ok  = ~w_trial[64];

  // ---------------- sign fix-up and result selection ------------------------
  logic [63:0] w_q_fix;
  logic [63:0] w_r_fix;
  logic [63:0] w_sel;
  logic [63:0] w_result;

  // Special-case values are already final, so they bypass negation.
  assign w_q_fix  = (!r_special && r_neg_q) ? (~r_quo + 64'd1) : r_quo;
  assign w_r_fix  = (!r_special && r_neg_r) ? (~r_rem + 64'd1) : r_rem;
  assign w_sel    = r_op_rem ? w_r_fix : w_q_fix;
  assign w_result = r_w32 ? {{32{w_sel[31]}}, w_sel[31:0]} : w_sel;

  // ---------------- next-state logic ----------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (START) w_state_next = w_special ? S_FIX : S_CALC;
      S_CALC:  if (r_cnt == 6'd63) w_state_next = S_FIX;
      S_FIX:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (ABORT) w_state_next = S_IDLE;
  end

  // ---------------- state and datapath registers ----------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= S_IDLE;
      r_cnt     <= 6'd0;
      r_quo     <= 64'd0;
      r_rem     <= 64'd0;
      r_divisor <= 64'd0;
      r_op_rem  <= 1'b0;
      r_w32     <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_special <= 1'b0;
      r_out     <= 64'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != S_IDLE);
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START && !ABORT) begin
            r_op_rem  <= OP[1];
            r_w32     <= W32;
            r_neg_q   <= w_x_neg ^ w_y_neg;
            r_neg_r   <= w_x_neg;
            r_special <= w_special;
            r_divisor <= w_y_mag;
            r_cnt     <= 6'd0;
            if (w_div_zero) begin
              r_quo <= 64'hFFFF_FFFF_FFFF_FFFF;
              r_rem <= w_x_ext;
            end else if (w_ovf) begin
              // The prepared dividend is exactly the overflow quotient in both widths.
              r_quo <= w_x_ext;
              r_rem <= 64'd0;
            end else begin
              r_quo <= w_x_mag;
              r_rem <= 64'd0;
            end
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 6'd1;
          if (w_trial_ok) begin
            r_rem <= w_trial[63:0];
            r_quo <= {r_quo[62:0], 1'b1};
          end else begin
            r_rem <= w_rem_shift[63:0];
            r_quo <= {r_quo[62:0], 1'b0};
          end
        end
        S_FIX: begin
          if (!ABORT) begin
            r_out  <= w_result;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign OUTPUT = r_out;
  assign BUSY   = r_busy;
  assign DONE   = r_done;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit -- self-checking bench for div_unit.
// Table-driven vectors plus hand-written control sequences; expected results
// are queued when a request is driven and compared when DONE appears.
// -----------------------------------------------------------------------------
module tb_div_unit;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [63:0] X;
  logic [63:0] Y;
  logic [1:0]  OP;
  logic        W32;
  logic        START;
  logic        ABORT;
  logic [63:0] OUTPUT;
  logic        BUSY;
  logic        DONE;

  div_unit dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .X       (X),
    .Y       (Y),
    .OP      (OP),
    .W32     (W32),
    .START   (START),
    .ABORT   (ABORT),
    .OUTPUT  (OUTPUT),
    .BUSY    (BUSY),
    .DONE    (DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  op;
    logic        w32;
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  logic [63:0] sb[$];
  logic [63:0] last_out;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic w32, input logic [63:0] x, input logic [63:0] y);
    OP = op; W32 = w32; X = x; Y = y; START = 1'b1;
  endtask

  task automatic issue(input logic [1:0] op, input logic w32, input logic [63:0] x,
                       input logic [63:0] y, input logic [63:0] exp);
    drive(op, w32, x, y);
    sb.push_back(exp);
  endtask

  // Called at the negedge where START was driven. Returns at the negedge
  // where DONE is observed (the DONE cycle). poke_at >= 1 drives a stray
  // START with other operands for three cycles while the unit is busy.
  task automatic wait_done(input string name, input int exp_lat, input int poke_at);
    int n;
    logic [63:0] e;
    n = 0;
    @(negedge CLK);
    START = 1'b0;
    check({name, " busy_after_start"}, {63'd0, BUSY}, 64'd1);
    check({name, " done_low_after_start"}, {63'd0, DONE}, 64'd0);
    while (!DONE && n < 200) begin
      @(negedge CLK);
      n++;
      if (n == poke_at) drive(2'd3, 1'b1, 64'd1, 64'd1);
      if (n == poke_at + 3) START = 1'b0;
    end
    START = 1'b0;
    if (!DONE) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no DONE within %0d cycles", name, n);
    end else begin
      check({name, " latency"}, 64'(n), 64'(exp_lat));
      check({name, " busy_at_done"}, {63'd0, BUSY}, 64'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s: DONE with empty scoreboard, got %h", name, OUTPUT);
      end else begin
        e = sb.pop_front();
        check({name, " result"}, OUTPUT, e);
        last_out = e;
      end
    end
  endtask

  initial begin
    logic seen_done;

    vecs[0]  = '{2'd1, 1'b0, 64'd100, 64'd7, 64'd14, 65};
    vecs[1]  = '{2'd3, 1'b0, 64'd100, 64'd7, 64'd2, 65};
    vecs[2]  = '{2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[3]  = '{2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[4]  = '{2'd2, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65};
    vecs[5]  = '{2'd0, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[6]  = '{2'd2, 1'b0, 64'd5, 64'd0, 64'd5, 1};
    vecs[7]  = '{2'd3, 1'b1, 64'h1234_5678_FFFF_FFF0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 1};
    vecs[8]  = '{2'd0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
    vecs[9]  = '{2'd2, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
    vecs[10] = '{2'd0, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
    vecs[11] = '{2'd0, 1'b1, 64'hAAAA_AAAA_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[12] = '{2'd1, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 65};
    vecs[13] = '{2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[14] = '{2'd0, 1'b0, 64'h8000_0000_0000_0000, 64'd3, 64'hD555_5555_5555_5556, 65};
    vecs[15] = '{2'd2, 1'b0, 64'h8000_0000_0000_0000, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[16] = '{2'd3, 1'b1, 64'hFFFF_FFFF_0000_0007, 64'h1234_5678_0000_0003, 64'd1, 65};

    RESET_N = 1'b0; START = 1'b0; ABORT = 1'b0;
    OP = 2'd0; W32 = 1'b0; X = 64'd0; Y = 64'd0;
    last_out = 64'd0;
    repeat (3) @(negedge CLK);
    check("reset OUTPUT", OUTPUT, 64'd0);
    check("reset BUSY", {63'd0, BUSY}, 64'd0);
    check("reset DONE", {63'd0, DONE}, 64'd0);
    RESET_N = 1'b1;
    @(negedge CLK);

    // ---- table-driven vectors ----
    for (int i = 0; i < NVEC; i++) begin
      issue(vecs[i].op, vecs[i].w32, vecs[i].x, vecs[i].y, vecs[i].exp);
      wait_done($sformatf("vec%0d", i), vecs[i].lat, -1);
      $display("vec%0d op=%0d w32=%0d x=%h y=%h out=%h", i, vecs[i].op, vecs[i].w32,
               vecs[i].x, vecs[i].y, OUTPUT);
    end

    // ---- START while busy is ignored ----
    @(negedge CLK);
    issue(2'd1, 1'b0, 64'd100, 64'd7, 64'd14);
    wait_done("busy_start", 65, 10);
    seen_done = 1'b0;
    repeat (80) begin
      @(negedge CLK);
      if (DONE) seen_done = 1'b1;
    end
    check("busy_start no_extra_done", {63'd0, seen_done}, 64'd0);
    $display("busy_start out=%h", OUTPUT);

    // ---- ABORT at cycle 30 ----
    drive(2'd1, 1'b0, 64'd1000, 64'd10);
    @(negedge CLK);
    START = 1'b0;
    repeat (29) @(negedge CLK);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    check("abort busy_low", {63'd0, BUSY}, 64'd0);
    seen_done = 1'b0;
    repeat (80) begin
      @(negedge CLK);
      if (DONE) seen_done = 1'b1;
    end
    check("abort no_done", {63'd0, seen_done}, 64'd0);
    check("abort output_held", OUTPUT, last_out);
    issue(2'd1, 1'b0, 64'd1000, 64'd10, 64'd100);
    wait_done("after_abort", 65, -1);
    $display("abort then restart out=%h", OUTPUT);

    // ---- asynchronous reset mid-CALC ----
    @(negedge CLK);
    drive(2'd0, 1'b0, 64'd12345, 64'd17);
    @(negedge CLK);
    START = 1'b0;
    repeat (19) @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    check("midreset OUTPUT", OUTPUT, 64'd0);
    check("midreset BUSY", {63'd0, BUSY}, 64'd0);
    check("midreset DONE", {63'd0, DONE}, 64'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    issue(2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    wait_done("after_reset", 65, -1);
    $display("reset then restart out=%h", OUTPUT);

    // ---- back-to-back: second START in the DONE cycle ----
    @(negedge CLK);
    issue(2'd3, 1'b0, 64'd100, 64'd7, 64'd2);
    wait_done("b2b_a", 65, -1);
    issue(2'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD);
    wait_done("b2b_b", 65, -1);
    $display("back-to-back out=%h", OUTPUT);

    @(negedge CLK);
    check("final done_one_cycle", {63'd0, DONE}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
